// File: rtl/bit_builder.sv
// bit_builder
// -----------
// Sequential word generator: expands a 6-bit position/count and a 2-bit mode
// into a 32-bit word, one bit per clock, and reports the number of 1s built.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high; clears all state
//   start     in   1   request pulse; accepted when idle (or in the done cycle)
//   type_sel  in   2   mode: 00 low-mask, 01 high-mask, 10 one-hot, 11 clear-below
//   pos       in   6   position/count operand, 0..63
//   base      in  32   source word, used by mode 11 only
//   busy      out  1   high while the word is being built
//   done      out  1   one-cycle pulse when result/ones are complete
//   result    out 32   constructed word (partial while busy)
//   ones      out  6   population count of result, 0..32
module bit_builder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  type_sel,
    input  logic [5:0]  pos,
    input  logic [31:0] base,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [5:0]  ones
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  pos_q, pos_d;
    logic [5:0]  p_q, p_d;
    logic [31:0] base_q, base_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  ones_q, ones_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [5:0]  idx_s;
    logic [5:0]  thr_s;
    logic        bit_s;

    // Value of the bit written at index i_q, from the latched operands.
    always_comb begin
        idx_s = {1'b0, i_q};
        thr_s = 6'd32 - p_q;
        bit_s = 1'b0;
        case (type_q)
            2'b00:   bit_s = (idx_s < p_q);
            2'b01:   bit_s = (idx_s >= thr_s);
            // One-hot uses the raw position so pos >= 32 yields an all-zero word.
            2'b10:   bit_s = (idx_s == pos_q);
            2'b11:   bit_s = base_q[i_q] & (idx_s >= p_q);
            default: bit_s = 1'b0;
        endcase
    end

    // Next-state and datapath update for the build sequence.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        type_d   = type_q;
        pos_d    = pos_q;
        p_d      = p_q;
        base_d   = base_q;
        result_d = result_q;
        ones_d   = ones_q;
        case (state_q)
            // The done cycle also accepts a new request, giving a 33-cycle
            // back-to-back turnaround.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    type_d   = type_sel;
                    pos_d    = pos;
                    p_d      = (pos > 6'd32) ? 6'd32 : pos;
                    base_d   = base;
                    i_d      = 5'd0;
                    result_d = 32'd0;
                    ones_d   = 6'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d[i_q] = bit_s;
                ones_d        = ones_q + {5'd0, bit_s};
                i_d           = i_q + 5'd1;
                if (i_q == 5'd31) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            i_q      <= 5'd0;
            type_q   <= 2'd0;
            pos_q    <= 6'd0;
            p_q      <= 6'd0;
            base_q   <= 32'd0;
            result_q <= 32'd0;
            ones_q   <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            type_q   <= type_d;
            pos_q    <= pos_d;
            p_q      <= p_d;
            base_q   <= base_d;
            result_q <= result_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ones   = ones_q;

endmodule

// File: tb/tb_bit_builder.sv
// tb_bit_builder
// --------------
// Directed bench for bit_builder. A transaction-level model predicts the
// word from mask arithmetic and tracks how many edges have elapsed since the
// accepting edge; a negedge process compares every output on every cycle.
// Each directed operation also checks literal hand-computed results.
module tb_bit_builder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  type_sel;
    logic [5:0]  pos;
    logic [31:0] base;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [5:0]  ones;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit_builder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .type_sel (type_sel),
        .pos      (pos),
        .base     (base),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ones     (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word the mode should produce, from plain mask arithmetic.
    function automatic logic [31:0] build_word(input logic [1:0] t, input logic [5:0] ps,
                                               input logic [31:0] b);
        int unsigned p;
        logic [63:0] low;
        p   = (ps > 6'd32) ? 32 : int'(ps);
        low = (64'd1 << p) - 64'd1;
        case (t)
            2'b00:   build_word = low[31:0];
            2'b01:   build_word = ~(((64'd1 << (32 - p)) - 64'd1) & 64'hFFFF_FFFF);
            2'b10:   build_word = (ps < 6'd32) ? (32'd1 << ps) : 32'd0;
            default: build_word = b & ~low[31:0];
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int k);
        logic [63:0] m;
        m = (64'd1 << k) - 64'd1;
        low_mask = m[31:0];
    endfunction

    // Model state: edges since the accepting edge, and the expected full word.
    bit          m_act  = 1'b0;
    int          m_k    = 0;
    logic [31:0] m_full = 32'd0;
    logic [31:0] m_hold = 32'd0;

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_act  <= 1'b0;
            m_k    <= 0;
            m_hold <= 32'd0;
        end else if (start && (!m_act || m_k == 32)) begin
            m_act  <= 1'b1;
            m_k    <= 0;
            m_full <= build_word(type_sel, pos, base);
        end else if (m_act) begin
            if (m_k == 32) begin
                m_act  <= 1'b0;
                m_hold <= m_full;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] e_res;
        if (chk_en) begin
            e_res = m_act ? (m_full & low_mask(m_k)) : m_hold;
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_act && m_k < 32)});
            chk("cyc_done", {31'd0, done}, {31'd0, (m_act && m_k == 32)});
            chk("cyc_result", result, e_res);
            chk("cyc_ones", {26'd0, ones}, $countones(e_res));
        end
    end

    // One operation: issue start, scramble inputs, wait for done, check literals.
    task automatic run_op(input logic [1:0] t, input logic [5:0] p, input logic [31:0] b,
                          input logic [31:0] er, input logic [5:0] eo, input string nm);
        int cnt;
        int bcnt;
        bit seen;
        @(negedge clk);
        type_sel = t; pos = p; base = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; type_sel = ~t; pos = ~p; base = ~b;
        cnt  = 1;
        bcnt = busy ? 1 : 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_latency"}, cnt, 32'd33);
        chk({nm, "_busy_cycles"}, bcnt, 32'd32);
        chk({nm, "_result"}, result, er);
        chk({nm, "_ones"}, {26'd0, ones}, {26'd0, eo});
    endtask

    initial begin
        int  cnt;
        bit  seen;
        reset = 1'b1; start = 1'b0; type_sel = 2'd0; pos = 6'd0; base = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ones", {26'd0, ones}, 32'd0);
        chk_en = 1'b1;

        run_op(2'b00, 6'd4,  32'h0, 32'h0000_000F, 6'd4,  "low4");
        run_op(2'b01, 6'd8,  32'h0, 32'hFF00_0000, 6'd8,  "high8");
        run_op(2'b00, 6'd0,  32'h0, 32'h0000_0000, 6'd0,  "low0");
        run_op(2'b00, 6'd40, 32'h0, 32'hFFFF_FFFF, 6'd32, "low40_sat");
        run_op(2'b01, 6'd40, 32'h0, 32'hFFFF_FFFF, 6'd32, "high40_sat");
        run_op(2'b10, 6'd31, 32'h0, 32'h8000_0000, 6'd1,  "hot31");
        run_op(2'b10, 6'd32, 32'h0, 32'h0000_0000, 6'd0,  "hot32");
        run_op(2'b11, 6'd16, 32'h0FFF_0010, 32'h0FFF_0000, 6'd12, "clr16");

        // Start during RUN is ignored; start in the done cycle restarts at E33.
        @(negedge clk);
        type_sel = 2'b00; pos = 6'd4; base = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        type_sel = 2'b01; pos = 6'd8; base = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 7; seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (done) seen = 1'b1;
        end
        chk("ign_done_seen", {31'd0, seen}, 32'd1);
        chk("ign_latency", cnt, 32'd33);
        chk("ign_result", result, 32'h0000_000F);
        chk("ign_ones", {26'd0, ones}, 32'd4);
        type_sel = 2'b10; pos = 6'd31; base = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("e33_busy", {31'd0, busy}, 32'd1);
        cnt = 1; seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (done) seen = 1'b1;
        end
        chk("e33_latency", cnt, 32'd33);
        chk("e33_result", result, 32'h8000_0000);

        // Reset at E10 of a run.
        @(negedge clk);
        type_sel = 2'b00; pos = 6'd20; base = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ones", {26'd0, ones}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("mid_rst_no_done", {31'd0, seen}, 32'd0);
        run_op(2'b00, 6'd20, 32'h0, 32'h000F_FFFF, 6'd20, "after_rst");

        repeat (3) @(negedge clk);
        chk("idle_hold_result", result, 32'h000F_FFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
